// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared constants and helpers for the FIR coefficient controller
// Purpose: default coefficient width, FSM state encoding and the tap-slice helper
//          used to place each tap on the flat coefficient bus.
// Ports:   none (package).
package fir_ctrl_pkg;

  localparam int DEF_COEF_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;

  // Lowest bit of tap k on a flat bus of coef_w-wide taps.
  function automatic int tap_lsb(input int k, input int coef_w);
    return k * coef_w;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow + active coefficient register file
// Purpose: TAPS x COEF_W shadow bank written one tap at a time, and an active bank
//          loaded from the whole shadow bank in a single edge.
// Ports:   clk, rst_n       clock, synchronous active-low reset (clears both banks)
//          wr_en/wr_addr/wr_data  pre-qualified shadow write
//          copy_en          shadow -> active transfer strobe
//          active_flat      active bank, tap k at [COEF_W*k +: COEF_W]
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = 27,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(TAPS)-1:0]   wr_addr,
  input  logic [COEF_W-1:0]         wr_data,
  input  logic                      copy_en,
  output logic [TAPS*COEF_W-1:0]    active_flat
);

  logic [COEF_W-1:0] shadow [TAPS];
  logic [COEF_W-1:0] active [TAPS];

  // wr_en is only asserted for in-range addresses, so the index never overruns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (copy_en) active <= shadow;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_flat
    assign active_flat[tap_lsb(k, COEF_W) +: COEF_W] = active[k];
  end

endmodule

// File: rtl/fir_coef_sched.sv
// rtl/fir_coef_sched.sv - FIR coefficient commit scheduler
// Purpose: qualifies host tap writes into the shadow bank, copies shadow to active on
//          the first input sample after a commit request, then holds out_valid low
//          for SETTLE input samples while the FIR delay line refills.
// Ports:   clk, rst_n                  clock, synchronous active-low reset
//          sample_en                   one strobe per FIR input sample
//          wr_en/wr_addr/wr_data       shadow tap write; wr_err pulses when rejected
//          commit_req / commit_ack     transfer request / pulse when active is updated
//          busy                        commit pending or settling
//          out_valid                   FIR output trustworthy
//          coefs                       flat active bank
module fir_coef_sched
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = 27,
  parameter int COEF_W = DEF_COEF_W,
  parameter int SETTLE = 27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic                      wr_en,
  input  logic [$clog2(TAPS)-1:0]   wr_addr,
  input  logic [COEF_W-1:0]         wr_data,
  output logic                      wr_err,
  input  logic                      commit_req,
  output logic                      commit_ack,
  output logic                      busy,
  output logic                      out_valid,
  output logic [TAPS*COEF_W-1:0]    coefs
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [1:0]    state;
  logic [CW-1:0] settle_cnt;
  logic          wr_ok;
  logic          copy_en;

  // Writes are frozen only while a copy is pending, so the committed image is
  // exactly what the shadow held when the request was accepted (plus that cycle's write).
  assign wr_ok   = wr_en && (32'(wr_addr) < TAPS) && (state != ST_PENDING);
  assign copy_en = (state == ST_PENDING) && sample_en;
  assign busy    = (state != ST_IDLE);

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_ok),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .copy_en     (copy_en),
    .active_flat (coefs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      wr_err     <= 1'b0;
      commit_ack <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      wr_err     <= wr_en && !wr_ok;
      commit_ack <= copy_en;
      case (state)
        ST_IDLE: begin
          // A sample_en in the request cycle is deliberately not used for the copy.
          if (commit_req) state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (sample_en) begin
            settle_cnt <= CW'(SETTLE);
            out_valid  <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // commit_req is ignored here; the host must retry once busy drops.
          if (sample_en) begin
            if (settle_cnt <= CW'(1)) begin
              settle_cnt <= '0;
              out_valid  <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              settle_cnt <= settle_cnt - CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_sched.sv
// tb/tb_fir_coef_sched.sv - directed self-checking bench for fir_coef_sched
module tb_fir_coef_sched;

  localparam int TAPS   = 27;
  localparam int COEF_W = 32;
  localparam int SETTLE = 27;

  logic                    tb_clk = 1'b0;
  logic                    rst_n;
  logic                    sample_en;
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [COEF_W-1:0]       wr_data;
  logic                    wr_err;
  logic                    commit_req;
  logic                    commit_ack;
  logic                    busy;
  logic                    out_valid;
  logic [TAPS*COEF_W-1:0]  coefs;

  fir_coef_sched #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (tb_clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .busy       (busy),
    .out_valid  (out_valid),
    .coefs      (coefs)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        cr;
    logic        se;
    logic        e_werr;
    logic        e_ack;
    logic        e_busy;
    logic        e_valid;
    int          tidx;
    logic [31:0] tval;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;
  logic ack_seen;

  function automatic vec_t mk(logic we, logic [4:0] addr, logic [31:0] data, logic cr, logic se,
                              logic e_werr, logic e_ack, logic e_busy, logic e_valid,
                              int tidx, logic [31:0] tval);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.cr = cr; v.se = se;
    v.e_werr = e_werr; v.e_ack = e_ack; v.e_busy = e_busy; v.e_valid = e_valid;
    v.tidx = tidx; v.tval = tval;
    return v;
  endfunction

  function automatic logic [31:0] tap(int k);
    return coefs[COEF_W*k +: COEF_W];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
    if (commit_ack === 1'b1) ack_seen = 1'b1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; commit_req = 0; sample_en = 0;
  endtask

  // n sample periods: three quiet clocks then one sample_en clock.
  task automatic sample_periods(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      repeat (3) tick();
      sample_en = 1;
      tick();
      sample_en = 0;
    end
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      wr_en = vq[i].we; wr_addr = vq[i].addr; wr_data = vq[i].data;
      commit_req = vq[i].cr; sample_en = vq[i].se;
      tick();
      chk($sformatf("%s[%0d].wr_err", tag, i), {31'b0, wr_err}, {31'b0, vq[i].e_werr});
      chk($sformatf("%s[%0d].ack", tag, i), {31'b0, commit_ack}, {31'b0, vq[i].e_ack});
      chk($sformatf("%s[%0d].busy", tag, i), {31'b0, busy}, {31'b0, vq[i].e_busy});
      chk($sformatf("%s[%0d].valid", tag, i), {31'b0, out_valid}, {31'b0, vq[i].e_valid});
      chk($sformatf("%s[%0d].tap%0d", tag, i, vq[i].tidx), tap(vq[i].tidx), vq[i].tval);
    end
    idle_inputs();
    vq.delete();
  endtask

  initial begin
    idle_inputs();
    ack_seen = 0;

    // Reset
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    chk("rst.coefs_zero", {31'b0, coefs == '0}, 32'd1);
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.wr_err", {31'b0, wr_err}, 32'd0);
    chk("rst.ack", {31'b0, commit_ack}, 32'd0);

    // Load all taps with k+1, then commit
    for (int k = 0; k < TAPS; k++) begin
      wr_en = 1; wr_addr = 5'(k); wr_data = 32'(k + 1);
      tick();
      chk($sformatf("load.wr_err%0d", k), {31'b0, wr_err}, 32'd0);
    end
    idle_inputs();
    commit_req = 1;
    tick();
    commit_req = 0;
    chk("load.busy_pending", {31'b0, busy}, 32'd1);
    chk("load.coefs_held", {31'b0, coefs == '0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("load.wait%0d.ack", i), {31'b0, commit_ack}, 32'd0);
      chk($sformatf("load.wait%0d.coefs_held", i), {31'b0, coefs == '0}, 32'd1);
    end
    sample_en = 1;
    tick();
    sample_en = 0;
    chk("load.ack", {31'b0, commit_ack}, 32'd1);
    chk("load.valid_low", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < TAPS; k++)
      chk($sformatf("load.tap%0d", k), tap(k), 32'(k + 1));
    tick();
    chk("load.ack_one_cycle", {31'b0, commit_ack}, 32'd0);
    sample_periods(SETTLE - 1);
    chk("load.valid_before_end", {31'b0, out_valid}, 32'd0);
    chk("load.busy_before_end", {31'b0, busy}, 32'd1);
    sample_periods(1);
    chk("load.valid_end", {31'b0, out_valid}, 32'd1);
    chk("load.busy_end", {31'b0, busy}, 32'd0);

    // Write while PENDING is rejected
    vq.push_back(mk(0, 5'd0, 32'h0,     1, 0,  0, 0, 1, 1,  3, 32'd4));
    vq.push_back(mk(1, 5'd3, 32'hDEAD,  0, 0,  1, 0, 1, 1,  3, 32'd4));
    vq.push_back(mk(0, 5'd0, 32'h0,     0, 0,  0, 0, 1, 1,  3, 32'd4));
    vq.push_back(mk(0, 5'd0, 32'h0,     0, 1,  0, 1, 1, 0,  3, 32'd4));
    vq.push_back(mk(0, 5'd0, 32'h0,     0, 0,  0, 0, 1, 0,  3, 32'd4));
    run_vecs("pend");

    // commit_req during SETTLE is ignored
    sample_periods(5);
    ack_seen = 0;
    commit_req = 1;
    tick();
    commit_req = 0;
    chk("settle_req.busy", {31'b0, busy}, 32'd1);
    sample_periods(SETTLE - 6);
    chk("settle_req.busy_hold", {31'b0, busy}, 32'd1);
    chk("settle_req.valid_hold", {31'b0, out_valid}, 32'd0);
    sample_periods(1);
    chk("settle_req.busy_end", {31'b0, busy}, 32'd0);
    chk("settle_req.valid_end", {31'b0, out_valid}, 32'd1);
    sample_periods(1);
    chk("settle_req.no_ack", {31'b0, ack_seen}, 32'd0);
    chk("settle_req.idle", {31'b0, busy}, 32'd0);

    // Bad address, then commit with same-cycle write and sample_en
    vq.push_back(mk(1, 5'd27, 32'd7,    0, 0,  1, 0, 0, 1,  0, 32'd1));
    vq.push_back(mk(0, 5'd0,  32'd0,    0, 0,  0, 0, 0, 1, 26, 32'd27));
    vq.push_back(mk(1, 5'd0,  32'd100,  1, 1,  0, 0, 1, 1,  0, 32'd1));
    vq.push_back(mk(0, 5'd0,  32'd0,    0, 0,  0, 0, 1, 1,  0, 32'd1));
    vq.push_back(mk(0, 5'd0,  32'd0,    0, 1,  0, 1, 1, 0,  0, 32'd100));
    vq.push_back(mk(0, 5'd0,  32'd0,    0, 0,  0, 0, 1, 0,  3, 32'd4));
    vq.push_back(mk(0, 5'd0,  32'd0,    0, 0,  0, 0, 1, 0, 26, 32'd27));
    run_vecs("badaddr");

    // Reset in the middle of SETTLE
    sample_periods(10);
    chk("midrst.busy_before", {31'b0, busy}, 32'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst.coefs_zero", {31'b0, coefs == '0}, 32'd1);
    chk("midrst.valid", {31'b0, out_valid}, 32'd0);
    chk("midrst.busy", {31'b0, busy}, 32'd0);
    chk("midrst.ack", {31'b0, commit_ack}, 32'd0);
    sample_periods(1);
    chk("midrst.idle_no_ack", {31'b0, commit_ack}, 32'd0);
    chk("midrst.idle_busy", {31'b0, busy}, 32'd0);
    commit_req = 1;
    tick();
    commit_req = 0;
    sample_en = 1;
    tick();
    sample_en = 0;
    chk("midrst.recommit_ack", {31'b0, commit_ack}, 32'd1);
    chk("midrst.shadow_cleared0", tap(0), 32'd0);
    chk("midrst.shadow_cleared26", tap(26), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
